// File: rtl/adc_range_reader.sv
// rtl/adc_range_reader.sv - Latch/shift sequencer that scans the ADC range monitor into a CPU-readable bank.
// Clip detection is built only when ADC_RANGE_READER_CLIP_EN is defined.
module adc_range_reader #(
    parameter int          SAMPLE_COUNT  = 8,
    parameter int          ADC_WIDTH     = 14,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          INTERVAL      = 125000,
    parameter logic [15:0] CLIP_LEVEL    = 16'h7F00,
    localparam int         WORDS         = 2 * SAMPLE_COUNT,
    localparam int         AW            = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                    sysClk,
    input  logic                    sysReset,
    input  logic                    enable,
    input  logic                    trigger,
    output logic                    rangeStrobe,
    output logic [1:0]              rangeCmd,
    input  logic [31:0]             rangeReadout,
    input  logic [AW-1:0]           cpuAddr,
    output logic [15:0]             cpuData,
    output logic                    busy,
    output logic                    scanDone,
    output logic [15:0]             scanCount,
    output logic [SAMPLE_COUNT-1:0] clipFlags,
    input  logic                    clipClear
);

    localparam int            NPUB          = 1 << AW;
    localparam int            SW            = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST   = SW'(SETTLE_CYCLES - 1);
    localparam logic [AW-1:0] K_LAST        = AW'(WORDS - 1);
    localparam logic [31:0]   INTERVAL_LAST = 32'(INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETTLE,
        S_CAPTURE,
        S_SHIFT,
        S_PUBLISH
    } state_t;

    state_t         r_state;
    logic           r_strobe;
    logic [1:0]     r_cmd;
    logic           r_busy;
    logic           r_done;
    logic [15:0]    r_count;
    logic [31:0]    r_interval;
    logic [SW-1:0]  r_settle;
    logic [AW-1:0]  r_k;
    logic [15:0]    r_shadow [WORDS];
    // Padded to a power of two so unused addresses read back as zero.
    logic [15:0]    r_pub    [NPUB];
    logic [15:0]    r_cpu_data;
    logic           w_unused;

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_state    <= S_IDLE;
            r_strobe   <= 1'b0;
            r_cmd      <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= 16'd0;
            r_interval <= 32'd0;
            r_settle   <= '0;
            r_k        <= '0;
            for (int i = 0; i < WORDS; i++) r_shadow[i] <= 16'd0;
            for (int i = 0; i < NPUB; i++) r_pub[i] <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (trigger || (enable && (r_interval == INTERVAL_LAST))) begin
                        r_interval <= 32'd0;
                        r_state    <= S_LATCH;
                        r_strobe   <= 1'b1;
                        r_cmd      <= 2'b01;
                        r_busy     <= 1'b1;
                        r_k        <= '0;
                    end else if (enable) begin
                        r_interval <= r_interval + 32'd1;
                    end else begin
                        r_interval <= 32'd0;
                    end
                end
                S_LATCH, S_SHIFT: begin
                    r_strobe <= 1'b0;
                    r_cmd    <= 2'b00;
                    r_settle <= '0;
                    r_state  <= S_SETTLE;
                    if (r_state == S_SHIFT) r_k <= r_k + AW'(1);
                end
                S_SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                S_CAPTURE: begin
                    r_shadow[r_k] <= rangeReadout[15:0];
                    if (r_k == K_LAST) begin
                        r_state <= S_PUBLISH;
                    end else begin
                        r_state  <= S_SHIFT;
                        r_strobe <= 1'b1;
                        r_cmd    <= 2'b10;
                    end
                end
                S_PUBLISH: begin
                    for (int i = 0; i < WORDS; i++) r_pub[i] <= r_shadow[i];
                    r_count <= r_count + 16'd1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_cpu_data <= 16'd0;
        end else begin
            r_cpu_data <= r_pub[cpuAddr];
        end
    end

`ifdef ADC_RANGE_READER_CLIP_EN
    localparam logic signed [16:0] CLIP_POS = {1'b0, CLIP_LEVEL};
    localparam logic signed [16:0] CLIP_NEG = -CLIP_POS;

    logic [SAMPLE_COUNT-1:0] r_clip;
    logic [SAMPLE_COUNT-1:0] w_clip_hit;

    always_comb begin
        w_clip_hit = '0;
        for (int i = 0; i < SAMPLE_COUNT; i++) begin
            w_clip_hit[i] = ($signed({r_shadow[2*i+1][15], r_shadow[2*i+1]}) >= CLIP_POS) ||
                            ($signed({r_shadow[2*i][15], r_shadow[2*i]}) <= CLIP_NEG);
        end
    end

    // A clip seen at publish outranks a clear on the same cycle.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_clip <= '0;
        end else if (r_state == S_PUBLISH) begin
            r_clip <= (clipClear ? '0 : r_clip) | w_clip_hit;
        end else if (clipClear) begin
            r_clip <= '0;
        end
    end

    assign clipFlags = r_clip;
    assign w_unused  = ^{rangeReadout[31:16], 16'(ADC_WIDTH)};
`else
    assign clipFlags = '0;
    assign w_unused  = ^{rangeReadout[31:16], clipClear, CLIP_LEVEL, 16'(ADC_WIDTH)};
`endif

    assign rangeStrobe = r_strobe;
    assign rangeCmd    = r_cmd;
    assign busy        = r_busy;
    assign scanDone    = r_done;
    assign scanCount   = r_count;
    assign cpuData     = r_cpu_data;

endmodule
